// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (I fetch, D load/store) and memory-side signals for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment (core + memory) view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      i_req_valid;
    logic                      i_req_ready;
    logic [ADDR_WIDTH-1:0]     i_addr;
    logic                      i_rsp_valid;
    logic [DATA_WIDTH-1:0]     i_rdata;

    logic                      d_req_valid;
    logic                      d_req_ready;
    logic                      d_we;
    logic [DATA_WIDTH/8-1:0]   d_be;
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic                      d_rsp_valid;
    logic [DATA_WIDTH-1:0]     d_rdata;

    logic                      mem_req;
    logic                      mem_gnt;
    logic                      mem_we;
    logic [DATA_WIDTH/8-1:0]   mem_be;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_rvalid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    logic                      spurious_rsp;

    modport slave (
        input  i_req_valid, i_addr,
        input  d_req_valid, d_we, d_be, d_addr, d_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output i_req_ready, i_rsp_valid, i_rdata,
        output d_req_ready, d_rsp_valid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output spurious_rsp
    );

    modport master (
        output i_req_valid, i_addr,
        output d_req_valid, d_we, d_be, d_addr, d_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  i_req_ready, i_rsp_valid, i_rdata,
        input  d_req_ready, d_rsp_valid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  spurious_rsp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (I) and load/store (D).
// D has fixed priority; a streak counter forces an I grant after STARVE_LIMIT back-to-back D grants.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t                r_state;
    logic [STREAK_W-1:0]   r_streak;
    logic                  r_spurious;

    logic                  w_idle;
    logic                  w_sel_d;
    logic                  w_sel_i;
    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BE_WIDTH-1:0]   w_be;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_rsp_i;
    logic                  w_rsp_d;

    // Reset gates selection and responses so every output reads 0 while rst is high.
    always_comb begin
        w_idle  = (r_state == IDLE) && !rst;
        w_sel_d = w_idle && bus.d_req_valid && !(bus.i_req_valid && (r_streak == LIMIT));
        w_sel_i = w_idle && !w_sel_d && bus.i_req_valid;
        w_hs    = (w_sel_d || w_sel_i) && bus.mem_gnt;
        w_rsp_i = !rst && (r_state == WAIT_I) && bus.mem_rvalid;
        w_rsp_d = !rst && (r_state == WAIT_D) && bus.mem_rvalid;
    end

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        if (w_sel_d) begin
            w_addr  = bus.d_addr;
            w_wdata = bus.d_wdata;
            w_be    = bus.d_be;
        end else if (w_sel_i) begin
            w_addr  = bus.i_addr;
        end
        w_rdata = bus.mem_rdata;
    end

    always_comb begin
        bus.mem_req      = w_sel_d || w_sel_i;
        bus.mem_we       = w_sel_d && bus.d_we;
        bus.mem_be       = w_be;
        bus.mem_addr     = w_addr;
        bus.mem_wdata    = w_wdata;
        bus.d_req_ready  = w_sel_d && bus.mem_gnt;
        bus.i_req_ready  = w_sel_i && bus.mem_gnt;
        bus.i_rsp_valid  = w_rsp_i;
        bus.i_rdata      = w_rsp_i ? w_rdata : '0;
        bus.d_rsp_valid  = w_rsp_d;
        bus.d_rdata      = w_rsp_d ? w_rdata : '0;
        bus.spurious_rsp = r_spurious && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_streak   <= '0;
            r_spurious <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.mem_rvalid) r_spurious <= 1'b1;
                    if (w_hs) r_state <= w_sel_d ? WAIT_D : WAIT_I;
                end
                WAIT_I, WAIT_D: begin
                    if (bus.mem_rvalid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Streak counts D grants only while I is waiting; any I grant or idle I clears it.
            if (!bus.i_req_valid || (w_hs && w_sel_i)) begin
                r_streak <= '0;
            end else if (w_hs && w_sel_d && (r_streak != LIMIT)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset/select table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        iv;
        logic        dv;
        logic        dwe;
        logic [3:0]  dbe;
        logic        gnt;
        logic        ereq;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic        eir;
        logic        edr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic quiet();
        bus.i_req_valid = 1'b0;
        bus.i_addr      = '0;
        bus.d_req_valid = 1'b0;
        bus.d_we        = 1'b0;
        bus.d_be        = '0;
        bus.d_addr      = '0;
        bus.d_wdata     = '0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic chk_all(input string t,
                           input logic ereq, input logic ewe, input logic [3:0] ebe,
                           input logic [31:0] eaddr, input logic [31:0] ewd,
                           input logic eir, input logic edr,
                           input logic eirv, input logic [31:0] eird,
                           input logic edrv, input logic [31:0] edrd,
                           input logic esp);
        chk({t, ".mem_req"},     64'(bus.mem_req),      64'(ereq));
        chk({t, ".mem_we"},      64'(bus.mem_we),       64'(ewe));
        chk({t, ".mem_be"},      64'(bus.mem_be),       64'(ebe));
        chk({t, ".mem_addr"},    64'(bus.mem_addr),     64'(eaddr));
        chk({t, ".mem_wdata"},   64'(bus.mem_wdata),    64'(ewd));
        chk({t, ".i_req_ready"}, 64'(bus.i_req_ready),  64'(eir));
        chk({t, ".d_req_ready"}, 64'(bus.d_req_ready),  64'(edr));
        chk({t, ".i_rsp_valid"}, 64'(bus.i_rsp_valid),  64'(eirv));
        chk({t, ".i_rdata"},     64'(bus.i_rdata),      64'(eird));
        chk({t, ".d_rsp_valid"}, 64'(bus.d_rsp_valid),  64'(edrv));
        chk({t, ".d_rdata"},     64'(bus.d_rdata),      64'(edrd));
        chk({t, ".spurious"},    64'(bus.spurious_rsp), 64'(esp));
    endtask

    // Reset with busy inputs applied: every output must still read 0.
    task automatic do_reset();
        tick();
        rst = 1'b1;
        quiet();
        bus.i_req_valid = 1'b1;
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h4444;
        bus.mem_gnt     = 1'b1;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = 32'h1357_9BDF;
        settle();
        chk_all("reset", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        quiet();
    endtask

    vec_t vecs[7];

    // Random-phase requester/memory state
    logic        r_iv, r_dv, r_dwe;
    logic [31:0] r_ia, r_da, r_dwd;
    logic [3:0]  r_dbe;
    logic        r_gnt, r_rv;
    logic [31:0] r_rd;
    int          lat;
    int          owner_q[$];
    int          dcnt;
    int          e_sel;
    logic        hs;

    initial begin
        quiet();
        rst = 1'b1;

        // ---------------- table: IDLE selection from a fresh reset ----------------
        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h1000, 32'h0,         1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 4'hF, 32'h2000, 32'hCAFE0001, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 4'h3, 32'h2000, 32'hCAFE0001, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'hCAFE0001, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h1000, 32'h0,         1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 4'h3, 32'h2000, 32'hCAFE0001, 1'b0, 1'b0};

        for (int k = 0; k < 7; k++) begin
            do_reset();
            tick();
            bus.i_req_valid = vecs[k].iv;
            bus.i_addr      = 32'h1000;
            bus.d_req_valid = vecs[k].dv;
            bus.d_we        = vecs[k].dwe;
            bus.d_be        = vecs[k].dbe;
            bus.d_addr      = 32'h2000;
            bus.d_wdata     = 32'hCAFE0001;
            bus.mem_gnt     = vecs[k].gnt;
            settle();
            chk_all($sformatf("vec%0d", k), vecs[k].ereq, vecs[k].ewe, vecs[k].ebe,
                    vecs[k].eaddr, vecs[k].ewd, vecs[k].eir, vecs[k].edr,
                    0, 0, 0, 0, 0);
            if (vecs[k].eir || vecs[k].edr) begin
                tick();
                quiet();
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hA5A5_0000 + 32'(k);
                settle();
                chk_all($sformatf("vec%0d.rsp", k), 0, 0, 4'h0, 0, 0, 0, 0,
                        vecs[k].eir, vecs[k].eir ? 32'hA5A5_0000 + 32'(k) : 32'h0,
                        vecs[k].edr, vecs[k].edr ? 32'hA5A5_0000 + 32'(k) : 32'h0, 0);
            end
        end

        // ---------------- D load, response two cycles after grant ----------------
        do_reset();
        tick();
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h100;
        bus.mem_gnt     = 1'b1;
        settle();
        chk_all("load.grant", 1, 0, 4'h0, 32'h100, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        quiet();
        settle();
        chk_all("load.wait", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        settle();
        chk_all("load.rsp", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        tick();
        quiet();
        settle();
        chk_all("load.after", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- store ----------------
        tick();
        bus.d_req_valid = 1'b1;
        bus.d_we        = 1'b1;
        bus.d_be        = 4'b0011;
        bus.d_addr      = 32'h200;
        bus.d_wdata     = 32'h1234;
        bus.mem_gnt     = 1'b1;
        settle();
        chk_all("store.grant", 1, 1, 4'b0011, 32'h200, 32'h1234, 0, 1, 0, 0, 0, 0, 0);
        tick();
        quiet();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77;
        settle();
        chk_all("store.ack", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0);

        // ---------------- starvation guard: D,D,D,D,I repeating ----------------
        do_reset();
        for (int g = 0; g < 10; g++) begin
            int exp_owner;
            int got_owner;
            exp_owner = (g % 5 == 4) ? 1 : 2;
            tick();
            bus.i_req_valid = 1'b1;
            bus.i_addr      = 32'h1000;
            bus.d_req_valid = 1'b1;
            bus.d_addr      = 32'h2000;
            bus.mem_gnt     = 1'b1;
            bus.mem_rvalid  = 1'b0;
            settle();
            got_owner = bus.d_req_ready ? 2 : (bus.i_req_ready ? 1 : 0);
            chk($sformatf("starve.grant%0d", g), 64'(got_owner), 64'(exp_owner));
            tick();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h5000 + 32'(g);
            settle();
            chk($sformatf("starve.irsp%0d", g), 64'(bus.i_rsp_valid), 64'(exp_owner == 1));
            chk($sformatf("starve.drsp%0d", g), 64'(bus.d_rsp_valid), 64'(exp_owner == 2));
        end

        // ---------------- grant stalled three cycles ----------------
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.d_req_valid = 1'b1;
            bus.d_addr      = 32'h300;
            bus.mem_gnt     = 1'b0;
            settle();
            chk($sformatf("stall.req%0d", k),   64'(bus.mem_req),     64'd1);
            chk($sformatf("stall.ready%0d", k), 64'(bus.d_req_ready), 64'd0);
            chk($sformatf("stall.addr%0d", k),  64'(bus.mem_addr),    64'h300);
        end
        tick();
        bus.mem_gnt = 1'b1;
        settle();
        chk("stall.ready_gnt", 64'(bus.d_req_ready), 64'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            settle();
            chk($sformatf("stall.wait_req%0d", k),   64'(bus.mem_req),     64'd0);
            chk($sformatf("stall.wait_ready%0d", k), 64'(bus.d_req_ready), 64'd0);
        end
        tick();
        quiet();
        bus.mem_rvalid = 1'b1;
        settle();
        chk("stall.rsp", 64'(bus.d_rsp_valid), 64'd1);

        // ---------------- spurious response in IDLE ----------------
        do_reset();
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h55;
        settle();
        chk_all("spur.pulse", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            quiet();
            settle();
            chk($sformatf("spur.sticky%0d", k), 64'(bus.spurious_rsp), 64'd1);
        end
        do_reset();
        tick();
        settle();
        chk("spur.cleared", 64'(bus.spurious_rsp), 64'd0);

        // ---------------- reset during WAIT_I ----------------
        tick();
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h800;
        bus.mem_gnt     = 1'b1;
        settle();
        chk("rstw.igrant", 64'(bus.i_req_ready), 64'd1);
        tick();
        quiet();
        rst = 1'b1;
        settle();
        chk_all("rstw.in_rst", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h9999;
        settle();
        chk_all("rstw.late_rsp", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        quiet();
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h900;
        bus.mem_gnt     = 1'b1;
        settle();
        chk_all("rstw.dgrant", 1, 0, 4'h0, 32'h900, 0, 0, 1, 0, 0, 0, 0, 1);
        tick();
        quiet();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hABCD;
        settle();
        chk_all("rstw.drsp", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'hABCD, 1);

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        r_iv = 1'b0; r_dv = 1'b0; r_dwe = 1'b0;
        r_ia = '0; r_da = '0; r_dwd = '0; r_dbe = '0;
        lat = 0; dcnt = 0;
        owner_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic        e_req, e_we, e_ir, e_dr, e_irv, e_drv;
            logic [3:0]  e_be;
            logic [31:0] e_addr, e_wd, e_ird, e_drd;
            tick();
            if (!r_iv && $urandom_range(0, 2) != 0) begin
                r_iv = 1'b1;
                r_ia = $urandom;
            end
            if (!r_dv && $urandom_range(0, 2) != 0) begin
                r_dv  = 1'b1;
                r_dwe = 1'($urandom_range(0, 1));
                r_dbe = 4'($urandom);
                r_da  = $urandom;
                r_dwd = $urandom;
            end
            r_gnt = ($urandom_range(0, 3) != 0);
            r_rv  = 1'b0;
            r_rd  = $urandom;
            if (owner_q.size() > 0) begin
                if (lat == 0) r_rv = 1'b1;
                else lat--;
            end
            bus.i_req_valid = r_iv;
            bus.i_addr      = r_ia;
            bus.d_req_valid = r_dv;
            bus.d_we        = r_dwe;
            bus.d_be        = r_dbe;
            bus.d_addr      = r_da;
            bus.d_wdata     = r_dwd;
            bus.mem_gnt     = r_gnt;
            bus.mem_rvalid  = r_rv;
            bus.mem_rdata   = r_rd;
            settle();

            // 0 = none, 1 = I, 2 = D
            e_sel = 0;
            if (owner_q.size() == 0) begin
                if (r_dv && !(r_iv && dcnt >= LIM)) e_sel = 2;
                else if (r_iv) e_sel = 1;
            end
            e_req  = (e_sel != 0);
            e_we   = (e_sel == 2) && r_dwe;
            e_be   = (e_sel == 2) ? r_dbe : 4'h0;
            e_addr = (e_sel == 2) ? r_da : ((e_sel == 1) ? r_ia : 32'h0);
            e_wd   = (e_sel == 2) ? r_dwd : 32'h0;
            e_ir   = (e_sel == 1) && r_gnt;
            e_dr   = (e_sel == 2) && r_gnt;
            e_irv  = r_rv && (owner_q.size() > 0) && (owner_q[0] == 1);
            e_drv  = r_rv && (owner_q.size() > 0) && (owner_q[0] == 2);
            e_ird  = e_irv ? r_rd : 32'h0;
            e_drd  = e_drv ? r_rd : 32'h0;
            chk_all($sformatf("rnd%0d", c), e_req, e_we, e_be, e_addr, e_wd,
                    e_ir, e_dr, e_irv, e_ird, e_drv, e_drd, 0);

            hs = e_req && r_gnt;
            if (r_rv) void'(owner_q.pop_front());
            if (!r_iv || (hs && e_sel == 1)) dcnt = 0;
            else if (hs && e_sel == 2 && dcnt < LIM) dcnt++;
            if (hs) begin
                owner_q.push_back(e_sel);
                lat = $urandom_range(0, 2);
                if (e_sel == 1) r_iv = 1'b0;
                else r_dv = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
